ascon_arb: RTL and testbench

ASCON_ARB -- requirements
Module: ascon_arb

---
 rtl/ascon_arb_if.sv | 69 ++++++
 rtl/ascon_arb.sv | 101 ++++++++++
 tb/tb_ascon_arb.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ascon_arb_if.sv
// Bus bundle between two Ascon requesters, the arbiter and the shared core.
// Ports: r_* requester-side streams, c_* core-side streams; master = arbiter.
interface ascon_arb_if #(
   parameter int CCW  = 32,
   parameter int CCSW = 32
);
   // requester side
   logic [1:0]           r_req;
   logic [1:0][3:0]      r_mode;
   logic [1:0][CCSW-1:0] r_key;
   logic [1:0]           r_key_valid;
   logic [1:0]           r_key_ready;
   logic [1:0][CCW-1:0]  r_bdi;
   logic [1:0][3:0]      r_bdi_valid;
   logic [1:0]           r_bdi_ready;
   logic [1:0][3:0]      r_bdi_type;
   logic [1:0]           r_bdi_eot;
   logic [1:0]           r_bdi_eoi;
   logic [1:0]           r_bdo_valid;
   logic [1:0]           r_bdo_ready;
   logic [CCW-1:0]       r_bdo;
   logic [3:0]           r_bdo_type;
   logic                 r_bdo_eot;
   logic                 r_auth;
   logic [1:0]           r_auth_valid;
   logic [1:0]           r_done;
   logic [1:0]           r_gnt;
   // core side
   logic [3:0]           c_mode;
   logic [CCSW-1:0]      c_key;
   logic                 c_key_valid;
   logic                 c_key_ready;
   logic [CCW-1:0]       c_bdi;
   logic [3:0]           c_bdi_valid;
   logic                 c_bdi_ready;
   logic [3:0]           c_bdi_type;
   logic                 c_bdi_eot;
   logic                 c_bdi_eoi;
   logic                 c_bdo_ready;
   logic [CCW-1:0]       c_bdo;
   logic                 c_bdo_valid;
   logic [3:0]           c_bdo_type;
   logic                 c_bdo_eot;
   logic                 c_auth;
   logic                 c_auth_valid;
   logic                 c_done;

   modport master (
      input  r_req, r_mode, r_key, r_key_valid, r_bdi, r_bdi_valid,
      input  r_bdi_type, r_bdi_eot, r_bdi_eoi, r_bdo_ready,
      input  c_key_ready, c_bdi_ready, c_bdo, c_bdo_valid, c_bdo_type,
      input  c_bdo_eot, c_auth, c_auth_valid, c_done,
      output r_key_ready, r_bdi_ready, r_bdo_valid, r_bdo, r_bdo_type,
      output r_bdo_eot, r_auth, r_auth_valid, r_done, r_gnt,
      output c_mode, c_key, c_key_valid, c_bdi, c_bdi_valid, c_bdi_type,
      output c_bdi_eot, c_bdi_eoi, c_bdo_ready
   );

   modport slave (
      output r_req, r_mode, r_key, r_key_valid, r_bdi, r_bdi_valid,
      output r_bdi_type, r_bdi_eot, r_bdi_eoi, r_bdo_ready,
      output c_key_ready, c_bdi_ready, c_bdo, c_bdo_valid, c_bdo_type,
      output c_bdo_eot, c_auth, c_auth_valid, c_done,
      input  r_key_ready, r_bdi_ready, r_bdo_valid, r_bdo, r_bdo_type,
      input  r_bdo_eot, r_auth, r_auth_valid, r_done, r_gnt,
      input  c_mode, c_key, c_key_valid, c_bdi, c_bdi_valid, c_bdi_type,
      input  c_bdi_eot, c_bdi_eoi, c_bdo_ready
   );
endinterface

// File: rtl/ascon_arb.sv
// Two-requester round-robin arbiter in front of one shared ascon_core.
// Ports: clk, rst (sync, active high), bus (ascon_arb_if.master).
module ascon_arb #(
   parameter int CCW  = 32,
   parameter int CCSW = 32
) (
   input  logic          clk,
   input  logic          rst,
   ascon_arb_if.master   bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_BUSY  = 2'd2;
   localparam logic [1:0] ST_REL   = 2'd3;

   logic [1:0]      r_state;
   logic            r_owner;
   logic            r_last;

   logic [1:0]      w_elig;
   logic            w_act;
   logic [CCSW-1:0] w_key;
   logic [CCW-1:0]  w_bdi;

   assign w_elig[0] = bus.r_req[0] & (bus.r_mode[0] != 4'd0);
   assign w_elig[1] = bus.r_req[1] & (bus.r_mode[1] != 4'd0);
   assign w_act     = (r_state != ST_IDLE);
   assign w_key     = bus.r_key[r_owner];
   assign w_bdi     = bus.r_bdi[r_owner];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (|w_elig) begin
                  r_state <= ST_START;
                  // on a tie the requester not served last wins
                  r_owner <= (&w_elig) ? ~r_last : w_elig[1];
               end
            end
            ST_START: r_state <= ST_BUSY;
            ST_BUSY: begin
               if (bus.c_done) r_state <= ST_REL;
            end
            ST_REL: begin
               r_last  <= r_owner;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      bus.c_mode       = 4'd0;
      bus.c_key        = '0;
      bus.c_key_valid  = 1'b0;
      bus.c_bdi        = '0;
      bus.c_bdi_valid  = 4'd0;
      bus.c_bdi_type   = 4'd0;
      bus.c_bdi_eot    = 1'b0;
      bus.c_bdi_eoi    = 1'b0;
      bus.c_bdo_ready  = 1'b0;
      bus.r_key_ready  = 2'b00;
      bus.r_bdi_ready  = 2'b00;
      bus.r_bdo_valid  = 2'b00;
      bus.r_gnt        = 2'b00;
      bus.r_done       = 2'b00;
      bus.r_auth_valid = 2'b00;
      if (w_act) begin
         bus.c_key                = w_key;
         bus.c_key_valid          = bus.r_key_valid[r_owner];
         bus.c_bdi                = w_bdi;
         bus.c_bdi_valid          = bus.r_bdi_valid[r_owner];
         bus.c_bdi_type           = bus.r_bdi_type[r_owner];
         bus.c_bdi_eot            = bus.r_bdi_eot[r_owner];
         bus.c_bdi_eoi            = bus.r_bdi_eoi[r_owner];
         bus.c_bdo_ready          = bus.r_bdo_ready[r_owner];
         bus.r_key_ready[r_owner] = bus.c_key_ready;
         bus.r_bdi_ready[r_owner] = bus.c_bdi_ready;
         bus.r_bdo_valid[r_owner] = bus.c_bdo_valid;
         bus.r_gnt[r_owner]       = 1'b1;
      end
      // mode is a one-cycle start strobe so the core never relaunches
      if (r_state == ST_START) bus.c_mode = bus.r_mode[r_owner];
      if (r_state == ST_REL) begin
         bus.r_done[r_owner]       = 1'b1;
         bus.r_auth_valid[r_owner] = bus.c_auth_valid;
      end
   end

   assign bus.r_bdo      = bus.c_bdo;
   assign bus.r_bdo_type = bus.c_bdo_type;
   assign bus.r_bdo_eot  = bus.c_bdo_eot;
   assign bus.r_auth     = bus.c_auth;

endmodule

// File: tb/tb_ascon_arb.sv
// Self-checking bench for ascon_arb; the bench plays both requesters
// and the shared core, comparing against table and hand-coded expectations.
module tb_ascon_arb;

   logic clk = 1'b0;
   logic rst;
   int   n_pass = 0;
   int   n_tot  = 0;

   always #5 clk = ~clk;

   ascon_arb_if #(.CCW(32), .CCSW(32)) bus ();

   ascon_arb #(.CCW(32), .CCSW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] bdi0, bdi1, key0, key1;
      logic [3:0]  bv0, bv1;
      logic [1:0]  kv, bdor;
      logic        cbr, ckr, cbv;
      logic [31:0] e_cbdi, e_ckey;
      logic [3:0]  e_cbv;
      logic        e_ckv, e_cbdor;
      logic [1:0]  e_rbr, e_rkr, e_rbv;
   } vec_t;

   vec_t tbl [3];
   vec_t sb [$];
   vec_t e;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int cnt;
   logic [1:0] exp_g [4];

   initial begin
      // owner is 1 while these are applied
      tbl[0] = '{bdi0:32'h11111111, bdi1:32'hDEADBEEF,
                 key0:32'hAAAA0000, key1:32'h5555FFFF,
                 bv0:4'hF, bv1:4'hF, kv:2'b10, bdor:2'b01,
                 cbr:1'b1, ckr:1'b1, cbv:1'b1,
                 e_cbdi:32'hDEADBEEF, e_ckey:32'h5555FFFF,
                 e_cbv:4'hF, e_ckv:1'b1, e_cbdor:1'b0,
                 e_rbr:2'b10, e_rkr:2'b10, e_rbv:2'b10};
      tbl[1] = '{bdi0:32'h0, bdi1:32'hCAFEF00D,
                 key0:32'h0, key1:32'h01234567,
                 bv0:4'h0, bv1:4'h3, kv:2'b01, bdor:2'b10,
                 cbr:1'b0, ckr:1'b1, cbv:1'b0,
                 e_cbdi:32'hCAFEF00D, e_ckey:32'h01234567,
                 e_cbv:4'h3, e_ckv:1'b0, e_cbdor:1'b1,
                 e_rbr:2'b00, e_rkr:2'b10, e_rbv:2'b00};
      tbl[2] = '{bdi0:32'hFFFFFFFF, bdi1:32'h0,
                 key0:32'hFFFFFFFF, key1:32'h0,
                 bv0:4'hF, bv1:4'h0, kv:2'b11, bdor:2'b11,
                 cbr:1'b1, ckr:1'b0, cbv:1'b1,
                 e_cbdi:32'h0, e_ckey:32'h0,
                 e_cbv:4'h0, e_ckv:1'b1, e_cbdor:1'b1,
                 e_rbr:2'b10, e_rkr:2'b00, e_rbv:2'b10};
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};

      bus.r_req = 2'b00;   bus.r_mode = '0;
      bus.r_key = '0;      bus.r_key_valid = 2'b11;
      bus.r_bdi = '0;      bus.r_bdi_valid = '1;
      bus.r_bdi_type = '0; bus.r_bdi_eot = 2'b00;
      bus.r_bdi_eoi = 2'b00; bus.r_bdo_ready = 2'b11;
      bus.c_key_ready = 1'b1; bus.c_bdi_ready = 1'b1;
      bus.c_bdo = 32'h12345678; bus.c_bdo_valid = 1'b1;
      bus.c_bdo_type = 4'h0; bus.c_bdo_eot = 1'b0;
      bus.c_auth = 1'b0; bus.c_auth_valid = 1'b1; bus.c_done = 1'b0;

      // reset state
      rst = 1'b1;
      step(); step();
      chk("rst_gnt", 32'(bus.r_gnt), 0);
      chk("rst_cmode", 32'(bus.c_mode), 0);
      chk("rst_done", 32'(bus.r_done), 0);
      chk("rst_rdy", {bus.r_key_ready, bus.r_bdi_ready,
                      bus.r_bdo_valid, bus.r_auth_valid}, 0);
      chk("rst_cval", {bus.c_key_valid, bus.c_bdi_valid,
                       bus.c_bdo_ready}, 0);
      chk("rst_bdo", bus.r_bdo, 32'h12345678);
      rst = 1'b0;
      bus.c_auth_valid = 1'b0;

      // single requester 1
      bus.r_req = 2'b10;
      bus.r_mode[1] = 4'd1;
      step();
      chk("s_gnt_start", 32'(bus.r_gnt), 2);
      chk("s_cmode_start", 32'(bus.c_mode), 1);
      bus.c_done = 1'b1;
      step();
      chk("s_cmode_busy", 32'(bus.c_mode), 0);
      chk("s_gnt_busy", 32'(bus.r_gnt), 2);
      bus.c_done = 1'b0;
      bus.r_req = 2'b00;
      step();
      chk("s_noabort", 32'(bus.r_gnt), 2);
      chk("s_nodone", 32'(bus.r_done), 0);

      // routing vectors through the scoreboard
      foreach (tbl[i]) begin
         bus.r_bdi[0] = tbl[i].bdi0; bus.r_bdi[1] = tbl[i].bdi1;
         bus.r_key[0] = tbl[i].key0; bus.r_key[1] = tbl[i].key1;
         bus.r_bdi_valid[0] = tbl[i].bv0;
         bus.r_bdi_valid[1] = tbl[i].bv1;
         bus.r_key_valid = tbl[i].kv;
         bus.r_bdo_ready = tbl[i].bdor;
         bus.c_bdi_ready = tbl[i].cbr;
         bus.c_key_ready = tbl[i].ckr;
         bus.c_bdo_valid = tbl[i].cbv;
         sb.push_back(tbl[i]);
         #1;
         e = sb.pop_front();
         chk($sformatf("v%0d_cbdi", i), bus.c_bdi, e.e_cbdi);
         chk($sformatf("v%0d_ckey", i), bus.c_key, e.e_ckey);
         chk($sformatf("v%0d_cbv", i), 32'(bus.c_bdi_valid), 32'(e.e_cbv));
         chk($sformatf("v%0d_ckv", i), 32'(bus.c_key_valid), 32'(e.e_ckv));
         chk($sformatf("v%0d_cbdor", i), 32'(bus.c_bdo_ready),
             32'(e.e_cbdor));
         chk($sformatf("v%0d_rbr", i), 32'(bus.r_bdi_ready), 32'(e.e_rbr));
         chk($sformatf("v%0d_rkr", i), 32'(bus.r_key_ready), 32'(e.e_rkr));
         chk($sformatf("v%0d_rbv", i), 32'(bus.r_bdo_valid), 32'(e.e_rbv));
      end

      // completion with tag
      bus.c_done = 1'b1; bus.c_auth_valid = 1'b1; bus.c_auth = 1'b1;
      step();
      bus.c_done = 1'b0;
      #1;
      chk("c_done", 32'(bus.r_done), 2);
      chk("c_authv", 32'(bus.r_auth_valid), 2);
      chk("c_auth", 32'(bus.r_auth), 1);
      step();
      chk("c_gnt_idle", 32'(bus.r_gnt), 0);
      chk("c_done_off", 32'(bus.r_done), 0);
      chk("c_authv_off", 32'(bus.r_auth_valid), 0);
      bus.c_auth_valid = 1'b0; bus.c_auth = 1'b0;

      // tie after reset: 0,1,0,1 with one idle cycle between grants
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.r_mode[0] = 4'd1; bus.r_mode[1] = 4'd2;
      bus.r_req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         cnt = 0;
         while (bus.r_gnt == 2'b00 && cnt < 10) begin
            step();
            cnt++;
         end
         chk($sformatf("t%0d_gnt", k), 32'(bus.r_gnt), 32'(exp_g[k]));
         chk($sformatf("t%0d_idle", k), cnt, 1);
         chk($sformatf("t%0d_cmode", k), 32'(bus.c_mode),
             (exp_g[k] == 2'b01) ? 1 : 2);
         step();
         bus.c_done = 1'b1;
         step();
         bus.c_done = 1'b0;
         #1;
         chk($sformatf("t%0d_done", k), 32'(bus.r_done), 32'(exp_g[k]));
         step();
      end
      bus.r_req = 2'b00;
      step();

      // reset in the middle of an operation
      bus.r_req = 2'b01; bus.r_mode[0] = 4'd3;
      step();
      chk("m_gnt", 32'(bus.r_gnt), 1);
      step();
      bus.r_req = 2'b00;
      bus.c_done = 1'b1;
      rst = 1'b1;
      step();
      chk("m_gnt_rst", 32'(bus.r_gnt), 0);
      chk("m_nodone", 32'(bus.r_done), 0);
      rst = 1'b0;
      bus.c_done = 1'b0;
      step();
      chk("m_nodone2", 32'(bus.r_done), 0);

      // requester with mode 0 is not eligible
      bus.r_req = 2'b01; bus.r_mode[0] = 4'd0; bus.r_mode[1] = 4'd5;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("i%0d_gnt", k), 32'(bus.r_gnt), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
